icache_ctrl: RTL

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_ctrl_pkg.sv | 40 ++++
 rtl/icache_line_array.sv | 58 +++++
 rtl/icache_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/icache_ctrl_pkg.sv
// ============================================================================
//  Module      : icache_ctrl_pkg
//  Description : Shared geometry, address-field helpers and FSM encodings for
//                the direct-mapped instruction cache (8 lines x 4 words).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_ctrl_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int ADDR_W     = 16;
  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 8;
  localparam int OFFSET_W   = 2;
  localparam int INDEX_W    = 3;
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;

  typedef logic [WORD_SIZE-1:0]                  word_t;
  typedef logic [LINE_WORDS-1:0][WORD_SIZE-1:0]  line_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_line_array.sv
// ============================================================================
//  Module      : icache_line_array
//  Description : Tag, valid and data storage of the instruction cache.
//                One asynchronous read port, one synchronous write port.
//  Ports       : Clk, Reset_N      - clock, async active-low reset (valid only)
//                clear_all         - invalidate every line on this edge
//                rd_index          - read port line select
//                rd_valid/tag/line - read port contents
//                wr_en/index/tag/line - line write, sets the line valid
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_line_array
  import icache_ctrl_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_N,
  input  logic               clear_all,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output line_t              rd_line,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  line_t              wr_line
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags  [NUM_LINES];
  line_t                lines [NUM_LINES];

  // A write in the same cycle as a clear still lands valid: the line being
  // filled comes from read-only instruction memory, so it cannot be stale.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      valid <= '0;
    end else begin
      if (clear_all) valid <= '0;
      if (wr_en)     valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      lines[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_line  = lines[rd_index];

endmodule

`default_nettype wire

// File: rtl/icache_ctrl.sv
// ============================================================================
//  Module      : icache_ctrl
//  Description : Direct-mapped instruction cache controller with 0-cycle hit,
//                line refill FSM (IDLE/FETCH/FILL) and hit/miss counters.
//  Ports       : Clk, Reset_N               - clock, async active-low reset
//                cpu_readM/cpu_address      - CPU fetch request (level)
//                cpu_data/cpu_ready         - fetch result, same-cycle on hit
//                flush                      - invalidate all lines
//                readM/address              - memory line read request
//                data1..data4/mem_ready     - memory line response
//                hit_count/miss_count       - wrapping performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_ctrl
  import icache_ctrl_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic              cpu_readM,
  input  logic [ADDR_W-1:0] cpu_address,
  output word_t             cpu_data,
  output logic              cpu_ready,
  input  logic              flush,
  output logic              readM,
  output logic [ADDR_W-1:0] address,
  input  word_t             data1,
  input  word_t             data2,
  input  word_t             data3,
  input  word_t             data4,
  input  logic              mem_ready,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] line_addr;
  line_t             fill_line;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  line_t             rd_line;
  logic              hit;
  logic              miss;

  icache_line_array u_array (
    .Clk       (Clk),
    .Reset_N   (Reset_N),
    .clear_all (flush),
    .rd_index  (addr_index(cpu_address)),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_en     (state == ST_FILL),
    .wr_index  (addr_index(line_addr)),
    .wr_tag    (addr_tag(line_addr)),
    .wr_line   (fill_line)
  );

  // Lookup only in IDLE; the pending request after FILL re-enters here and
  // is served (and counted) as an ordinary hit.
  assign hit  = (state == ST_IDLE) && cpu_readM && rd_valid &&
                (rd_tag == addr_tag(cpu_address));
  assign miss = (state == ST_IDLE) && cpu_readM && !hit;

  assign cpu_ready = hit;
  assign cpu_data  = rd_line[addr_offset(cpu_address)];
  assign readM     = (state == ST_FETCH);
  assign address   = line_addr;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state      <= ST_IDLE;
      line_addr  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (miss) begin
            line_addr  <= {addr_tag(cpu_address), addr_index(cpu_address), 2'b00};
            miss_count <= miss_count + 16'd1;
            state      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (mem_ready) state <= ST_FILL;
        end
        ST_FILL: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      if (hit) hit_count <= hit_count + 16'd1;
    end
  end

  // Line capture buffer is pure datapath and needs no reset.
  always_ff @(posedge Clk) begin
    if (state == ST_FETCH && mem_ready) begin
      fill_line <= {data4, data3, data2, data1};
    end
  end

endmodule

`default_nettype wire
